uart_tx: RTL and testbench
==========================

# uart_tx

Buffered 8N1 UART transmitter, the outbound counterpart to the matrix controller's UART receive path. It sends status and acknowledgement bytes from the control logic back to the host over a dedicated pin. A small FIFO accepts bytes from the control logic, and the transmitter serialises them at a fixed baud rate derived from the root oscillator clock.

## Interface

Parameters:
- CLOCK_DIVIDER, 61: clk_in cycles per bit. 7 MHz / 61 gives about 114.75 kbaud, within 0.4 % of 115200. Legal range is 2..65535.
- FIFO_DEPTH_LOG2, 2: log2 of the FIFO depth. The default gives 4 entries. Legal range is 1..4.

Ports:
- clk_in  input  1  root clock. All logic runs on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to enqueue.
- write  input  1  enqueue strobe, sampled each cycle.
- full  output  1  FIFO holds 2^FIFO_DEPTH_LOG2 entries.
- empty  output  1  FIFO holds 0 entries.
- busy  output  1  High when the FSM is not in IDLE or the FIFO is not empty.
- tx  output  1  serial line. It idles high.

## Operation

Reset values:
- tx=1, full=0, empty=1, busy=0.
- FSM is in IDLE.
- FIFO count, read pointer and write pointer are all 0.
- Baud counter and bit index are both 0.

FIFO:
- A write is accepted on an edge where write=1 and full=0. data_in is stored at the write pointer.
- A write while full=1 is dropped silently. FIFO contents are unchanged.
- full and empty are decoded from the registered count. They do not depend on a same-cycle pop.
  - A write in a cycle where full=1 is dropped even if the FSM pops in that same cycle.
- Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo 2^FIFO_DEPTH_LOG2. The count width is FIFO_DEPTH_LOG2+1 bits.

FSM states: IDLE, START, DATA, STOP.
- IDLE → START: when empty=0. On that transition:
  - pop the head into the shift register,
  - set tx<=0,
  - set the baud counter to 0.
- START: hold tx=0 for CLOCK_DIVIDER cycles. Then go to DATA with bit index 0 and tx<=shift[0].
- DATA: each bit lasts CLOCK_DIVIDER cycles, sent LSB first.
  - At the end of each bit, shift right and increment the bit index.
  - After bit 7, go to STOP with tx<=1.
- STOP: hold tx=1 for CLOCK_DIVIDER cycles. On the final stop-bit cycle:
  - if empty=0, pop and go directly to START with tx<=0, so there is no idle gap;
  - otherwise go to IDLE.
- Baud counter counts 0..CLOCK_DIVIDER-1. The bit ends on the cycle where the counter equals CLOCK_DIVIDER-1.
- The shift register holds its byte for the whole frame. Later FIFO writes never alter a frame in flight.

## Timing

- Latency: with the FSM in IDLE and the FIFO empty, a write accepted at edge E0 makes empty=0 after E0. tx falls at E1.
- Frame length is exactly 10×CLOCK_DIVIDER cycles, measured from the falling edge of the start bit to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- A write on the same edge as the STOP-state pop check is not visible to that check, because empty is registered.
  - The FSM goes to IDLE and starts the frame one cycle later, with a one-cycle idle-high gap.
- Reset mid-frame: on the reset edge tx returns to 1 and the FIFO is emptied. Pending and in-flight bytes are lost.
- All outputs are registered. tx has no combinational path from any input.

## Test plan

- Reset: hold reset for 3 cycles, then release. Required: tx=1, empty=1, full=0, busy=0 on every cycle of reset and after it, with no transitions.
- Single byte, CLOCK_DIVIDER=4: write 0xA5 once. Required:
  - tx falls one edge after acceptance;
  - tx reads 0,1,0,1,0,0,1,0,1,1, each value for exactly 4 cycles;
  - then empty=1 and busy=0.
- Overflow, CLOCK_DIVIDER=4, depth 4: write 0x01..0x06 on 6 consecutive cycles.
  - Required: bytes 0x01..0x05 are transmitted in order, because one entry is popped before the 6th write.
  - The 6th write sees full=1 and is dropped. full is asserted for exactly the cycles where count=4.
- Back-to-back: write 0x00 and 0xFF consecutively. Required:
  - two frames totalling 80 cycles with CLOCK_DIVIDER=4;
  - the second start bit begins immediately after the first stop bit, with no extra high cycle.
- Late write: with the FIFO empty, write 0x3C on the final stop-bit cycle of the previous frame. Required:
  - exactly one idle-high cycle between the frames;
  - then the correct 0x3C frame.
- Reset mid-frame: assert reset during data bit 3 of a frame with 2 bytes queued. Required:
  - tx=1 on the next edge, with empty=1 and busy=0;
  - no further frames after reset is released.

Source files
------------

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: small byte FIFO feeding a start/data/stop serialiser.
// Latency: a byte written into an idle, empty transmitter starts its start bit one edge later.
// Backpressure: full is high while the FIFO holds its maximum count; writes made while full are dropped.
module uart_tx #(
  parameter int CLOCK_DIVIDER   = 61,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [15:0] BAUD_LAST = 16'(CLOCK_DIVIDER - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic [FIFO_DEPTH_LOG2:0]   w_count_nxt;
  logic                       r_full;
  logic                       r_empty;
  logic                       r_busy;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_baud;
  logic [15:0] w_baud_nxt;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_tx;
  logic        w_tx_nxt;

  logic        w_push;
  logic        w_pop;
  logic        w_bit_end;

  // Full/empty come from the registered count, so a same-cycle pop never frees room for a write.
  assign w_push    = write && !r_full;
  assign w_bit_end = (r_baud == BAUD_LAST);

  assign full  = r_full;
  assign empty = r_empty;
  assign busy  = r_busy;
  assign tx    = r_tx;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; no reset needed since validity is tracked by the count.
  always_ff @(posedge clk_in) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, count and the registered status flags.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
      r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
    end
  end

  // Serialiser state register and datapath registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic: each bit lasts CLOCK_DIVIDER cycles; STOP chains straight into START when data waits.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random writes compared each cycle against a frame-level model.
// Latency: every output is sampled on the falling edge after each rising edge.
// Backpressure: the model drops writes made while it holds a full queue.
module tb_uart_tx;

  localparam int D     = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 1 << LOG2;

  logic       clk_in  = 1'b0;
  logic       reset   = 1'b1;
  logic       write   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx;

  always #5 clk_in = ~clk_in;

  uart_tx #(
    .CLOCK_DIVIDER   (D),
    .FIFO_DEPTH_LOG2 (LOG2)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .data_in (data_in),
    .write   (write),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .tx      (tx)
  );

  int checks   = 0;
  int failures = 0;
  int n        = -1;

  // Frame-level reference: a queue of accepted bytes and the edge at which the current frame began.
  logic [7:0] q[$];
  bit         factive = 1'b0;
  int         fstart  = 0;
  logic [7:0] fbyte   = 8'h00;

  function automatic logic exp_tx();
    int k;
    if (!factive) return 1'b1;
    k = (n - fstart) / D;
    if (k == 0) return 1'b0;
    if (k <= 8) return fbyte[k-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst, input logic wr, input logic [7:0] d);
    int pre_size;
    if (rst) begin
      q.delete();
      factive = 1'b0;
    end else begin
      pre_size = q.size();
      if (factive && n == fstart + 10 * D) factive = 1'b0;
      if (!factive && q.size() > 0) begin
        fbyte   = q.pop_front();
        fstart  = n;
        factive = 1'b1;
      end
      if (wr && pre_size < DEPTH) q.push_back(d);
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, n, obs, expv);
    end
  endtask

  task automatic step(input logic rst, input logic wr, input logic [7:0] d);
    reset   = rst;
    write   = wr;
    data_in = d;
    @(posedge clk_in);
    n++;
    model_edge(rst, wr, d);
    @(negedge clk_in);
    check("tx",    tx,    exp_tx());
    check("empty", empty, q.size() == 0);
    check("full",  full,  q.size() == DEPTH);
    check("busy",  busy,  factive || (q.size() != 0));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  logic [9:0] a5_pat;
  logic [7:0] rb;
  int         guard;

  initial begin
    // Reset held for three cycles, then quiet line afterwards.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(5);

    // Single byte 0xA5 against a fixed bit pattern as well as the model.
    a5_pat = 10'b1101001010;
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 10 * D; i++) begin
      step(1'b0, 1'b0, 8'h00);
      check("a5_pattern", tx, a5_pat[i / D]);
    end
    step(1'b0, 1'b0, 8'h00);
    check("a5_done_empty", empty, 1'b1);
    check("a5_done_busy",  busy,  1'b0);
    idle(3);

    // Random single byte.
    rb = 8'($urandom);
    step(1'b0, 1'b1, rb);
    idle(10 * D + 4);

    // Overflow: six consecutive writes into a depth-4 FIFO.
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
    idle(5 * 10 * D + 8);

    // Back-to-back frames 0x00 then 0xFF.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    idle(2 * 10 * D + 4);

    // Late write on the final stop-bit edge produces a single idle-high cycle.
    rb = 8'($urandom);
    step(1'b0, 1'b1, rb);
    idle(10 * D);
    step(1'b0, 1'b1, 8'h3C);
    check("late_gap_tx", tx, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check("late_start_tx", tx, 1'b0);
    idle(10 * D + 4);

    // Random write traffic, then drain.
    for (int i = 0; i < 150; i++) begin
      step(1'b0, ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    idle(DEPTH * 10 * D + 20);

    // Reset during data bit 3 with two bytes queued behind the frame in flight.
    step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    guard = 0;
    while (!(factive && (n - fstart) / D == 4) && guard < 100) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    checks++;
    assert (guard < 100) else begin
      failures++;
      $error("FAIL reach_data_bit3 cyc=%0d observed=timeout expected=reached", n);
    end
    step(1'b1, 1'b0, 8'h00);
    check("rst_mid_tx",    tx,    1'b1);
    check("rst_mid_empty", empty, 1'b1);
    check("rst_mid_busy",  busy,  1'b0);
    idle(12 * D);
    check("post_rst_tx",   tx,    1'b1);
    check("post_rst_busy", busy,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
